// File: rtl/logic_alu_seq.sv
// rtl/logic_alu_seq.sv - sequential N-bit logic ALU with bit-serial shifter
//
// Accepts {op, a, b} on a valid/ready handshake, executes AND/OR/XOR in one
// step or SHR/SHL one bit per cycle, then holds the registered result and
// status until the consumer takes it.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   request handshake (op, a, b sampled on accept)
//   op [2:0]              000 AND, 001 OR, 010 XOR, 011 SHR, 100 SHL, else illegal
//   a, b [N-1:0]          operands; for shifts a is the source, b the amount
//   out_valid / out_ready result handshake
//   result [N-1:0]        registered result
//   flag_z, flag_n        result == 0, result MSB
//   flag_c                last bit shifted out (0 for non-shift / shift by 0)
//   err                   illegal opcode
//
// Build option: define LOGIC_ALU_SEQ_FLAGS_EN to generate flag_z/flag_n/flag_c;
// without it those outputs are tied to 0.

module logic_alu_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         flag_z,
  output logic         flag_n,
  output logic         flag_c,
  output logic         err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;

  // cnt must hold values 0..N
  localparam int               CW      = $clog2(N + 1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(N);
  localparam logic [N-1:0]     N_AS_B  = N'(N);

  state_t        state_q, state_d;
  logic [N-1:0]  result_q, result_d;  // doubles as the shift working register
  logic [CW-1:0] cnt_q, cnt_d;
  logic          shl_q, shl_d;
  logic          err_q, err_d;
  logic          accept;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = (state_q == S_IDLE) && in_valid;
  assign result    = result_q;
  assign err       = err_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    shl_d    = shl_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          err_d   = 1'b0;
          state_d = S_DONE;
          case (op)
            OP_AND: result_d = a & b;
            OP_OR:  result_d = a | b;
            OP_XOR: result_d = a ^ b;
            OP_SHR, OP_SHL: begin
              shl_d    = (op == OP_SHL);
              result_d = a;
              if (b != '0) begin
                // amounts >= N would only shift zeros in; cap at N steps
                cnt_d   = (b >= N_AS_B) ? CNT_MAX : b[CW-1:0];
                state_d = S_SHIFT;
              end
            end
            default: begin
              result_d = '0;
              err_d    = 1'b1;
            end
          endcase
        end
      end
      S_SHIFT: begin
        if (shl_q) result_d = {result_q[N-2:0], 1'b0};
        else       result_d = {1'b0, result_q[N-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      cnt_q    <= '0;
      shl_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      shl_q    <= shl_d;
      err_q    <= err_d;
    end
  end

`ifdef LOGIC_ALU_SEQ_FLAGS_EN
  logic flag_z_q, flag_z_d;
  logic flag_n_q, flag_n_d;
  logic flag_c_q, flag_c_d;
  logic enter_done;

  // z/n are captured once from the final result so they stay frozen in DONE
  assign enter_done = (state_q != S_DONE) && (state_d == S_DONE);

  always_comb begin
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    flag_c_d = flag_c_q;
    if (accept) begin
      flag_c_d = 1'b0;
    end else if (state_q == S_SHIFT) begin
      flag_c_d = shl_q ? result_q[N-1] : result_q[0];
    end
    if (enter_done) begin
      flag_z_d = (result_d == '0);
      flag_n_d = result_d[N-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
      flag_c_q <= flag_c_d;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
  assign flag_c = flag_c_q;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
  assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_logic_alu_seq.sv
// tb/tb_logic_alu_seq.sv - self-checking bench for logic_alu_seq (N=4)

module tb_logic_alu_seq;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'b000;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] result;
  logic         flag_z, flag_n, flag_c, err;

  int n_cmp = 0;
  int n_mis = 0;

  logic_alu_seq #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] res;
    logic         z;
    logic         n;
    logic         c;
    logic         e;
    int           lat;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    int           hold;
    bit           poke;
  } vec_t;

  exp_t sb[$];

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t         e;
    int           k;
    logic [N-1:0] r;
    logic         c;
    k = (int'(y) > N) ? N : int'(y);
    c = 1'b0;
    e.e = 1'b0;
    e.lat = 1;
    case (o)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b010: r = x ^ y;
      3'b011: begin
        r = x >> k;
        if (k > 0) c = x[k-1];
        e.lat = 1 + k;
      end
      3'b100: begin
        r = x << k;
        if (k > 0) c = x[N-k];
        e.lat = 1 + k;
      end
      default: begin
        r = '0;
        e.e = 1'b1;
      end
    endcase
    e.res = r;
`ifdef LOGIC_ALU_SEQ_FLAGS_EN
    e.z = (r == '0);
    e.n = r[N-1];
    e.c = c;
`else
    e.z = 1'b0;
    e.n = 1'b0;
    e.c = 1'b0;
`endif
    return e;
  endfunction

  // Drive one request, wait for its result, hold it for `hold` cycles, consume.
  task automatic do_req(input vec_t v);
    exp_t e;
    int   lat;
    @(negedge clk);
    chk("in_ready_before_req", int'(in_ready), 1);
    in_valid = 1'b1;
    op = v.op;
    a  = v.a;
    b  = v.b;
    @(posedge clk);
    sb.push_back(model(v.op, v.a, v.b));
    #1;
    in_valid = 1'b0;
    op = 3'($urandom);
    a  = N'($urandom);
    b  = N'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("out_valid_seen", int'(out_valid), 1);
    chk("latency", lat, e.lat);
    chk("result", int'(result), int'(e.res));
    chk("flag_z", int'(flag_z), int'(e.z));
    chk("flag_n", int'(flag_n), int'(e.n));
    chk("flag_c", int'(flag_c), int'(e.c));
    chk("err", int'(err), int'(e.e));
    chk("in_ready_in_done", int'(in_ready), 0);
    for (int i = 0; i < v.hold; i++) begin
      if (v.poke && i == 1) in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_result", int'(result), int'(e.res));
      chk("hold_flag_z", int'(flag_z), int'(e.z));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_after_consume", int'(in_ready), 1);
    chk("out_valid_after_consume", int'(out_valid), 0);
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{op: 3'b000, a: 4'b1100, b: 4'b1010, hold: 0, poke: 1'b0},
      '{op: 3'b001, a: 4'b0101, b: 4'b0010, hold: 0, poke: 1'b0},
      '{op: 3'b100, a: 4'b0011, b: 4'd2,    hold: 0, poke: 1'b0},
      '{op: 3'b011, a: 4'b1011, b: 4'd1,    hold: 0, poke: 1'b0},
      '{op: 3'b100, a: 4'b1001, b: 4'd7,    hold: 0, poke: 1'b0},
      '{op: 3'b010, a: 4'b0101, b: 4'b0101, hold: 5, poke: 1'b1},
      '{op: 3'b111, a: 4'b1111, b: 4'b1111, hold: 1, poke: 1'b0},
      '{op: 3'b000, a: 4'b1111, b: 4'b0110, hold: 0, poke: 1'b0},
      '{op: 3'b011, a: 4'b1010, b: 4'd0,    hold: 0, poke: 1'b0},
      '{op: 3'b100, a: 4'b1101, b: 4'd4,    hold: 0, poke: 1'b0},
      '{op: 3'b011, a: 4'b1000, b: 4'd3,    hold: 2, poke: 1'b1},
      '{op: 3'b101, a: 4'b0110, b: 4'b0011, hold: 0, poke: 1'b0},
      '{op: 3'b010, a: 4'b1001, b: 4'b0011, hold: 0, poke: 1'b0}
    };

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_flags", int'({flag_z, flag_n, flag_c}), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;

    foreach (vecs[i]) do_req(vecs[i]);

    // reset while a 4-step SHR is in flight
    @(negedge clk);
    in_valid = 1'b1;
    op = 3'b011;
    a  = 4'b1111;
    b  = 4'd4;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_shift_not_done", int'(out_valid), 0);
    chk("mid_shift_in_ready", int'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_late_result", int'(out_valid), 0);
    end
    do_req('{op: 3'b001, a: 4'b0001, b: 4'b0010, hold: 0, poke: 1'b0});

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
